// File: rtl/axis_operand_split.sv
// rtl/axis_operand_split.sv - splits one interleaved operand stream into paired A/B streams
// Odd-length packets are completed with a zero B operand and flagged on ERR_ODD.
module axis_operand_split #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] IN_TDATA,
  input  logic                  IN_TLAST,
  input  logic                  IN_TVALID,
  output logic                  IN_TREADY,
  output logic [DATA_WIDTH-1:0] A_TDATA,
  output logic                  A_TLAST,
  output logic                  A_TVALID,
  input  logic                  A_TREADY,
  output logic [DATA_WIDTH-1:0] B_TDATA,
  output logic                  B_TLAST,
  output logic                  B_TVALID,
  input  logic                  B_TREADY,
  output logic                  ERR_ODD,
  output logic [CNT_WIDTH-1:0]  PAIR_COUNT
);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] a_data_q, b_data_q;
  logic                  a_last_q, b_last_q;
  logic                  a_valid_q, b_valid_q;
  logic                  err_odd_q;
  logic [CNT_WIDTH-1:0]  pair_cnt_q;

  logic done;
  logic in_xfer;
  logic load_a_slot;

  // A side that already handshook no longer gates completion of the pair.
  assign done        = (state_q == PRESENT) && (!a_valid_q || A_TREADY) && (!b_valid_q || B_TREADY);
  assign IN_TREADY   = (state_q != PRESENT) || done;
  assign in_xfer     = IN_TVALID && IN_TREADY;
  assign load_a_slot = in_xfer && (state_q != LOAD_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD_A;
      a_data_q   <= '0;
      b_data_q   <= '0;
      a_last_q   <= 1'b0;
      b_last_q   <= 1'b0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      err_odd_q  <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      if (state_q == PRESENT) begin
        if (a_valid_q && A_TREADY) a_valid_q <= 1'b0;
        if (b_valid_q && B_TREADY) b_valid_q <= 1'b0;
        if (done) begin
          pair_cnt_q <= pair_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          state_q    <= LOAD_A;
        end
      end

      // Later assignments override the PRESENT bookkeeping above on fall-through.
      if (load_a_slot) begin
        a_data_q <= IN_TDATA;
        if (IN_TLAST) begin
          b_data_q  <= '0;
          a_last_q  <= 1'b1;
          b_last_q  <= 1'b1;
          err_odd_q <= 1'b1;
          a_valid_q <= 1'b1;
          b_valid_q <= 1'b1;
          state_q   <= PRESENT;
        end else begin
          state_q <= LOAD_B;
        end
      end

      if (in_xfer && (state_q == LOAD_B)) begin
        b_data_q  <= IN_TDATA;
        a_last_q  <= IN_TLAST;
        b_last_q  <= IN_TLAST;
        a_valid_q <= 1'b1;
        b_valid_q <= 1'b1;
        state_q   <= PRESENT;
      end
    end
  end

  assign A_TDATA    = a_data_q;
  assign A_TLAST    = a_last_q;
  assign A_TVALID   = a_valid_q;
  assign B_TDATA    = b_data_q;
  assign B_TLAST    = b_last_q;
  assign B_TVALID   = b_valid_q;
  assign ERR_ODD    = err_odd_q;
  assign PAIR_COUNT = pair_cnt_q;

endmodule

// File: tb/tb_axis_operand_split.sv
// tb/tb_axis_operand_split.sv - directed and randomized checks of axis_operand_split
// Reference model: per-side FIFOs of expected {tlast,tdata} built from accepted input words.
module tb_axis_operand_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IN_TDATA = '0;
  logic        IN_TLAST = 1'b0;
  logic        IN_TVALID = 1'b0;
  logic        IN_TREADY;
  logic [31:0] A_TDATA;
  logic        A_TLAST;
  logic        A_TVALID;
  logic        A_TREADY = 1'b0;
  logic [31:0] B_TDATA;
  logic        B_TLAST;
  logic        B_TVALID;
  logic        B_TREADY = 1'b0;
  logic        ERR_ODD;
  logic [15:0] PAIR_COUNT;

  axis_operand_split #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .IN_TDATA(IN_TDATA), .IN_TLAST(IN_TLAST), .IN_TVALID(IN_TVALID), .IN_TREADY(IN_TREADY),
    .A_TDATA(A_TDATA), .A_TLAST(A_TLAST), .A_TVALID(A_TVALID), .A_TREADY(A_TREADY),
    .B_TDATA(B_TDATA), .B_TLAST(B_TLAST), .B_TVALID(B_TVALID), .B_TREADY(B_TREADY),
    .ERR_ODD(ERR_ODD), .PAIR_COUNT(PAIR_COUNT)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] a_q[$];
  logic [32:0] b_q[$];
  logic [31:0] pend_a;
  bit          have_a;
  int          na, nb;
  logic [15:0] cnt_base;
  bit          err_exp;
  bit          a_stall, b_stall;
  logic [32:0] a_prev, b_prev;
  int          n_ticks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    a_q.delete(); b_q.delete();
    have_a = 0; na = 0; nb = 0; cnt_base = '0; err_exp = 0;
    a_stall = 0; b_stall = 0;
  endtask

  function automatic logic [15:0] exp_count();
    int m = (na < nb) ? na : nb;
    return 16'(int'(cnt_base) + m);
  endfunction

  // One clock: starts and ends at a negedge; handshakes are judged just before the posedge.
  task automatic tick(input bit iv, input logic [31:0] d, input bit il, input bit ar, input bit br,
                      output bit took);
    logic [32:0] e;
    chk("pair_count", PAIR_COUNT, exp_count());
    chk("err_odd", ERR_ODD, err_exp);
    if (a_stall) begin
      chk("a_hold_valid", A_TVALID, 1);
      chk("a_hold_word", {A_TLAST, A_TDATA}, a_prev);
    end
    if (b_stall) begin
      chk("b_hold_valid", B_TVALID, 1);
      chk("b_hold_word", {B_TLAST, B_TDATA}, b_prev);
    end
    IN_TVALID = iv; IN_TDATA = d; IN_TLAST = il; A_TREADY = ar; B_TREADY = br;
    #1;
    chk("in_tready", IN_TREADY, !((A_TVALID && !ar) || (B_TVALID && !br)));
    took = iv && IN_TREADY;
    if (A_TVALID && ar) begin
      if (a_q.size() == 0) chk("a_spurious", A_TVALID, 0);
      else begin e = a_q.pop_front(); chk("a_word", {A_TLAST, A_TDATA}, e); na++; end
    end
    if (B_TVALID && br) begin
      if (b_q.size() == 0) chk("b_spurious", B_TVALID, 0);
      else begin e = b_q.pop_front(); chk("b_word", {B_TLAST, B_TDATA}, e); nb++; end
    end
    a_stall = A_TVALID && !ar; a_prev = {A_TLAST, A_TDATA};
    b_stall = B_TVALID && !br; b_prev = {B_TLAST, B_TDATA};
    if (took) begin
      if (!have_a) begin
        if (il) begin
          a_q.push_back({1'b1, d}); b_q.push_back({1'b1, 32'h0}); err_exp = 1;
        end else begin
          pend_a = d; have_a = 1;
        end
      end else begin
        a_q.push_back({il, pend_a}); b_q.push_back({il, d}); have_a = 0;
      end
    end
    n_ticks++;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input bit il, input bit ar, input bit br, input bit rnd);
    bit took = 0;
    for (int i = 0; i < 64 && !took; i++) begin
      if (rnd) tick(($urandom_range(0, 3) != 0), d, il, ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) != 0), took);
      else tick(1'b1, d, il, ar, br, took);
    end
    if (!took) chk("send_timeout", took, 1);
  endtask

  task automatic drain(input bit rnd);
    bit took;
    for (int i = 0; i < 64 && (a_q.size() != 0 || b_q.size() != 0); i++)
      tick(1'b0, 32'h0, 1'b0, rnd ? ($urandom_range(0, 1) != 0) : 1'b1,
           rnd ? ($urandom_range(0, 1) != 0) : 1'b1, took);
    chk("drain_left", a_q.size() + b_q.size(), 0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, took);
  endtask

  initial begin
    bit          took;
    int          t0;
    logic [15:0] c0;
    logic [31:0] w;
    int          len;

    model_reset();
    #2;
    chk("rst_a_valid", A_TVALID, 0);
    chk("rst_b_valid", B_TVALID, 0);
    chk("rst_words", {A_TLAST, A_TDATA, B_TLAST, B_TDATA}, 0);
    chk("rst_count", PAIR_COUNT, 0);
    chk("rst_err", ERR_ODD, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Test 1: single clean pair
    send(32'h3F800000, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h40000000, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(1'b0);
    chk("t1_count", PAIR_COUNT, 16'd1);
    chk("t1_err", ERR_ODD, 0);

    // Test 2: 8-word packet at full rate
    t0 = n_ticks;
    for (int i = 0; i < 8; i++) send(32'h41000000 + 32'(i), (i == 7), 1'b1, 1'b1, 1'b0);
    chk("t2_cycles", n_ticks - t0, 8);
    drain(1'b0);
    chk("t2_count", PAIR_COUNT, 16'd5);

    // Test 3: B stalls for five cycles while A is accepted
    send(32'h3F800000, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h40000000, 1'b1, 1'b1, 1'b0, 1'b0);
    c0 = PAIR_COUNT;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, took);
      chk("t3_blocked", took, 0);
    end
    chk("t3_a_dropped", A_TVALID, 0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, took);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, took);
    chk("t3_count", PAIR_COUNT, c0 + 16'd1);

    // Test 4: odd packet, then a clean one
    send(32'h3F800000, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h40000000, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h40400000, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(1'b0);
    chk("t4_err", ERR_ODD, 1);
    send(32'h40800000, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h40A00000, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(1'b0);
    chk("t4_err_sticky", ERR_ODD, 1);

    // Test 5: asynchronous reset while a pair is presented
    send(32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h22222222, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_presented", {A_TVALID, B_TVALID}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("t5_a_valid", A_TVALID, 0);
    chk("t5_b_valid", B_TVALID, 0);
    chk("t5_count", PAIR_COUNT, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send(32'h33333333, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h44444444, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(1'b0);

    // Test 6: counter wrap
    force dut.pair_cnt_q = 16'hFFFF;
    #1 release dut.pair_cnt_q;
    cnt_base = 16'hFFFF - 16'((na < nb) ? na : nb);
    send(32'h55555555, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h66666666, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(1'b0);
    chk("t6_wrap", PAIR_COUNT, 16'h0000);

    // Randomized packets with random gaps and backpressure
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        send(w, (i == len - 1), 1'b0, 1'b0, 1'b1);
      end
    end
    drain(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
